// File: rtl/m68k_bus_initiator.sv
// 68000-style bus master: runs one asynchronous bus cycle (S0-S7) per request.
// It waits on DTACK and reports completion, bus error, timeout or illegal byte enables.
module m68k_bus_initiator #(
    parameter int TIMEOUT = 255,
    parameter int TOW     = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req,
    input  logic        req_rw,
    input  logic [22:0] req_addr,
    input  logic [1:0]  req_be,
    input  logic [15:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic [22:0] A_o,
    output logic        addr_oe,
    input  logic [15:0] D_i,
    output logic [15:0] D_o,
    output logic        D_oe,
    output logic        _AS,
    output logic        _UDS,
    output logic        _LDS,
    output logic        RW,
    input  logic        _DTACK,
    input  logic        _BERR
);

    typedef enum logic [3:0] {IDLE, S0, S1, S2, S3, S4, S5, S6, S7} state_t;

    state_t         state, nxt_state;
    logic [TOW-1:0] wait_cnt, nxt_cnt;
    logic           abort, nxt_abort;
    logic           rw_q, nxt_rw;
    logic [1:0]     be_q, nxt_be;
    logic [22:0]    nxt_addr;
    logic [15:0]    nxt_wdata, nxt_rdata;
    logic           dtack_s, berr_s;
    logic           live, strobe_win;
    logic           nxt_busy, nxt_done, nxt_err, nxt_addr_oe, nxt_d_oe;
    logic           nxt_as, nxt_uds, nxt_lds, nxt_rw_pin;

    // Next-state logic; bus outputs are decoded from the next state so that every
    // pin comes straight off a flop and cannot glitch.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = wait_cnt;
        nxt_abort = abort;
        nxt_rw    = rw_q;
        nxt_be    = be_q;
        nxt_addr  = A_o;
        nxt_wdata = D_o;
        nxt_rdata = rdata;

        case (state)
            IDLE: begin
                if (req) begin
                    nxt_be    = req_be;
                    nxt_abort = (req_be == 2'b00);
                    nxt_cnt   = '0;
                    if (req_be != 2'b00) begin
                        nxt_rw    = req_rw;
                        nxt_addr  = req_addr;
                        nxt_wdata = req_wdata;
                        nxt_state = S0;
                    end else begin
                        nxt_state = S7;
                    end
                end
            end
            S0: nxt_state = S1;
            S1: nxt_state = S2;
            S2: nxt_state = S3;
            S3: nxt_state = S4;
            // A timeout drains through S5/S6 so its done lands where an acknowledge
            // after TIMEOUT wait states would have put it.
            S4: begin
                if (!berr_s) begin
                    nxt_state = S7;
                    nxt_abort = 1'b1;
                end else if (!dtack_s) begin
                    nxt_state = S5;
                end else if (wait_cnt == TOW'(TIMEOUT)) begin
                    nxt_state = S5;
                    nxt_abort = 1'b1;
                end else begin
                    nxt_cnt = wait_cnt + 1'b1;
                end
            end
            S5: nxt_state = S6;
            S6: begin
                nxt_state = S7;
                if (rw_q && !abort) begin
                    nxt_rdata = D_i;
                end
            end
            S7:      nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase

        live        = (nxt_state != IDLE) && (nxt_be != 2'b00);
        strobe_win  = nxt_rw ? (nxt_state inside {S2, S3, S4, S5, S6})
                             : (nxt_state inside {S4, S5, S6});
        nxt_busy    = (nxt_state != IDLE);
        nxt_done    = (nxt_state == S7);
        nxt_err     = (nxt_state == S7) && nxt_abort;
        nxt_addr_oe = live;
        nxt_rw_pin  = live ? nxt_rw : 1'b1;
        nxt_as      = !(live && (nxt_state inside {S2, S3, S4, S5, S6}));
        nxt_uds     = !(live && strobe_win && nxt_be[1]);
        nxt_lds     = !(live && strobe_win && nxt_be[0]);
        nxt_d_oe    = live && !nxt_rw && (nxt_state inside {S3, S4, S5, S6, S7});
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            wait_cnt <= '0;
            abort    <= 1'b0;
            rw_q     <= 1'b1;
            be_q     <= 2'b00;
            dtack_s  <= 1'b1;
            berr_s   <= 1'b1;
            A_o      <= '0;
            D_o      <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            addr_oe  <= 1'b0;
            D_oe     <= 1'b0;
            _AS      <= 1'b1;
            _UDS     <= 1'b1;
            _LDS     <= 1'b1;
            RW       <= 1'b1;
        end else begin
            state    <= nxt_state;
            wait_cnt <= nxt_cnt;
            abort    <= nxt_abort;
            rw_q     <= nxt_rw;
            be_q     <= nxt_be;
            dtack_s  <= _DTACK;
            berr_s   <= _BERR;
            A_o      <= nxt_addr;
            D_o      <= nxt_wdata;
            rdata    <= nxt_rdata;
            busy     <= nxt_busy;
            done     <= nxt_done;
            err      <= nxt_err;
            addr_oe  <= nxt_addr_oe;
            D_oe     <= nxt_d_oe;
            _AS      <= nxt_as;
            _UDS     <= nxt_uds;
            _LDS     <= nxt_lds;
            RW       <= nxt_rw_pin;
        end
    end

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Bench for m68k_bus_initiator: directed and randomized bus cycles compared every CLK
// against a phase-window timing model of the S0-S7 cycle.
module tb_m68k_bus_initiator;

    localparam int TIMEOUT = 4;
    localparam int TOW     = 8;
    localparam int K_ACK   = 0;
    localparam int K_BERR  = 1;
    localparam int K_NONE  = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req;
    logic        req_rw;
    logic [22:0] req_addr;
    logic [1:0]  req_be;
    logic [15:0] req_wdata;
    logic        busy, done, err;
    logic [15:0] rdata;
    logic [22:0] A_o;
    logic        addr_oe;
    logic [15:0] D_i;
    logic [15:0] D_o;
    logic        D_oe;
    logic        _AS, _UDS, _LDS, RW;
    logic        _DTACK, _BERR;

    int          checks = 0;
    int          errors = 0;
    int          txn    = 0;
    logic [15:0] rdata_model = 16'h0;

    always #5 CLK = ~CLK;

    m68k_bus_initiator #(.TIMEOUT(TIMEOUT), .TOW(TOW)) dut (
        .CLK(CLK), .RST(RST),
        .req(req), .req_rw(req_rw), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .A_o(A_o), .addr_oe(addr_oe), .D_i(D_i), .D_o(D_o), .D_oe(D_oe),
        ._AS(_AS), ._UDS(_UDS), ._LDS(_LDS), .RW(RW),
        ._DTACK(_DTACK), ._BERR(_BERR)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Vector layout: busy,done,err,addr_oe,D_oe,_AS,_UDS,_LDS,RW,A_o[22:0],D_o[15:0].
    // j counts CLKs after the acceptance edge; len is the cycle index where done shows.
    function automatic logic [63:0] expectVec(input int j, input int len, input logic rw,
                                              input logic [1:0] be, input logic abort,
                                              input logic [22:0] addr, input logic [15:0] wdata);
        logic act, live, as_low, win, doe;
        act    = (j <= len);
        live   = act && (be != 2'b00);
        as_low = live && (j >= 2) && (j <= len - 1);
        win    = live && (rw ? (j >= 2) : (j >= 4)) && (j <= len - 1);
        doe    = live && !rw && (j >= 3);
        return {16'h0, act, act && (j == len), act && (j == len) && abort, live, doe,
                !as_low, !(win && be[1]), !(win && be[0]), live ? rw : 1'b1,
                live ? addr : 23'h0, doe ? wdata : 16'h0};
    endfunction

    function automatic logic [63:0] observe(input logic [63:0] ev);
        return {16'h0, busy, done, err, addr_oe, D_oe, _AS, _UDS, _LDS, RW,
                ev[44] ? A_o : 23'h0, ev[43] ? D_o : 16'h0};
    endfunction

    // One request: kind selects DTACK, BERR or silence from S4 wait index n.
    // hold keeps req high afterwards; chained starts at the current negedge.
    // reset_at >= 0 pulses RST at that cycle index instead of finishing the cycle.
    task automatic applyStimulus(input logic rw, input logic [22:0] addr, input logic [1:0] be,
                                 input logic [15:0] wdata, input logic [15:0] bus_data,
                                 input int kind, input int n, input bit hold, input bit chained,
                                 input int reset_at);
        int          len;
        logic        abort;
        logic [63:0] ev;
        if (!chained) @(negedge CLK);
        req       = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wdata;
        D_i       = bus_data;
        if (be == 2'b00) begin
            len = 0; abort = 1'b1;
        end else if (kind == K_BERR) begin
            len = 5 + n; abort = 1'b1;
        end else if (kind == K_NONE) begin
            len = 7 + TIMEOUT; abort = 1'b1;
        end else begin
            len = 7 + n; abort = 1'b0;
        end
        txn++;
        @(posedge CLK);
        for (int j = 0; j <= len + 1; j++) begin
            @(negedge CLK);
            if (j == reset_at) begin
                RST = 1'b1;
                #1;
                ev = expectVec(len + 1, len, rw, be, abort, addr, wdata);
                checkOutput($sformatf("txn%0d.rst_async", txn), observe(ev), ev);
                rdata_model = 16'h0;
                checkOutput($sformatf("txn%0d.rst_rdata", txn), {48'h0, rdata}, {48'h0, rdata_model});
                @(negedge CLK);
                RST     = 1'b0;
                _DTACK  = 1'b1;
                _BERR   = 1'b1;
                for (int m = 0; m < 3; m++) begin
                    @(negedge CLK);
                    checkOutput($sformatf("txn%0d.rst_nodone%0d", txn, m), {63'h0, done}, 64'h0);
                end
                break;
            end
            ev = expectVec(j, len, rw, be, abort, addr, wdata);
            checkOutput($sformatf("txn%0d.cyc%0d", txn, j), observe(ev), ev);
            if (j == len) begin
                if (be != 2'b00 && rw && !abort) rdata_model = bus_data;
                checkOutput($sformatf("txn%0d.rdata", txn), {48'h0, rdata}, {48'h0, rdata_model});
            end
            if (j == 0 && !hold) req = 1'b0;
            _DTACK = !(be != 2'b00 && kind != K_NONE && j >= 3 + n && j < len);
            _BERR  = !(be != 2'b00 && kind == K_BERR && j >= 3 + n && j < len);
        end
    endtask

    initial begin
        RST       = 1'b1;
        req       = 1'b0;
        req_rw    = 1'b1;
        req_addr  = 23'h0;
        req_be    = 2'b00;
        req_wdata = 16'h0;
        D_i       = 16'h0;
        _DTACK    = 1'b1;
        _BERR     = 1'b1;
        repeat (2) @(negedge CLK);
        checkOutput("reset_pins", {16'h0, busy, done, err, addr_oe, D_oe, _AS, _UDS, _LDS, RW, A_o, D_o},
                    {16'h0, 5'b00000, 4'b1111, 23'h0, 16'h0});
        checkOutput("reset_rdata", {48'h0, rdata}, 64'h0);
        RST = 1'b0;
        @(negedge CLK);

        applyStimulus(1'b1, 23'h3FFFF8, 2'b11, 16'h0000, 16'hA5C3, K_ACK, 0, 1'b0, 1'b0, -1);
        applyStimulus(1'b0, 23'h012345, 2'b10, 16'h1234, 16'h0000, K_ACK, 3, 1'b0, 1'b0, -1);
        applyStimulus(1'b1, 23'h000100, 2'b11, 16'h0000, 16'hBEEF, K_BERR, 0, 1'b0, 1'b0, -1);
        applyStimulus(1'b1, 23'h0055AA, 2'b01, 16'h0000, 16'h7777, K_NONE, 0, 1'b0, 1'b0, -1);
        applyStimulus(1'b0, 23'h2AAAAA, 2'b11, 16'hC0DE, 16'h0000, K_ACK, 0, 1'b0, 1'b0, 5);
        applyStimulus(1'b1, 23'h001000, 2'b11, 16'h0000, 16'h1111, K_ACK, 0, 1'b1, 1'b0, -1);
        applyStimulus(1'b1, 23'h001000, 2'b11, 16'h0000, 16'h2222, K_ACK, 1, 1'b0, 1'b1, -1);
        applyStimulus(1'b1, 23'h000007, 2'b00, 16'h0000, 16'h3333, K_ACK, 0, 1'b0, 1'b0, -1);

        for (int t = 0; t < 40; t++) begin
            logic       rw;
            logic [1:0] be;
            int         kind, n, r;
            rw   = 1'($urandom_range(0, 1));
            be   = 2'($urandom_range(0, 3));
            r    = $urandom_range(0, 9);
            kind = (r < 6) ? K_ACK : ((r < 8) ? K_BERR : K_NONE);
            n    = $urandom_range(0, TIMEOUT - 1);
            applyStimulus(rw, 23'($urandom), be, 16'($urandom), 16'($urandom), kind, n, 1'b0, 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
